// File: rtl/inst_issue_queue_pkg.sv
// Shared constants for the instruction issue queue: type codes, op ids,
// instruction field positions and the decoded-instruction record.
package inst_issue_queue_pkg;

  localparam int XLEN_DEF = 32;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_VEC    = 7'b1010111;

  typedef enum logic [1:0] {
    QUE_NONE   = 2'd0,
    QUE_REG    = 2'd1,
    QUE_STORE  = 2'd2,
    QUE_BRANCH = 2'd3
  } que_type_e;

  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,  OP_ADD   = 6'd1,  OP_SUB   = 6'd2,  OP_SLL   = 6'd3,
    OP_SLT   = 6'd4,  OP_SLTU  = 6'd5,  OP_XOR   = 6'd6,  OP_SRL   = 6'd7,
    OP_SRA   = 6'd8,  OP_OR    = 6'd9,  OP_AND   = 6'd10, OP_ADDI  = 6'd11,
    OP_SLTI  = 6'd12, OP_SLTIU = 6'd13, OP_XORI  = 6'd14, OP_ORI   = 6'd15,
    OP_ANDI  = 6'd16, OP_SLLI  = 6'd17, OP_SRLI  = 6'd18, OP_SRAI  = 6'd19,
    OP_LUI   = 6'd20, OP_AUIPC = 6'd21, OP_JAL   = 6'd22, OP_JALR  = 6'd23,
    OP_BEQ   = 6'd24, OP_BNE   = 6'd25, OP_BLT   = 6'd26, OP_BGE   = 6'd27,
    OP_BLTU  = 6'd28, OP_BGEU  = 6'd29, OP_LB    = 6'd30, OP_LH    = 6'd31,
    OP_LW    = 6'd32, OP_LBU   = 6'd33, OP_LHU   = 6'd34, OP_SB    = 6'd35,
    OP_SH    = 6'd36, OP_SW    = 6'd37, OP_VADD  = 6'd38
  } op_name_e;

  typedef struct packed {
    que_type_e   typ;
    op_name_e    name;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        is_vec;
    logic        is_imm;
    logic        is_pc;
  } dec_t;

endpackage

// File: rtl/inst_issue_queue_if.sv
// Fetch-side, operand-side and issue-side signals of the issue queue.
interface inst_issue_queue_if
  import inst_issue_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = XLEN_DEF
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              rdy;
  logic              flush;
  logic              enq_valid;
  logic [XLEN-1:0]   enq_inst;
  logic [XLEN-1:0]   enq_pc;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              ovf_err;
  logic [4:0]        pre_rs1;
  logic [4:0]        pre_rs2;
  logic              op1_rdy;
  logic              op2_rdy;
  logic              dst_ready;
  logic              issue_valid;
  logic [1:0]        iss_type;
  logic [5:0]        iss_name;
  logic [4:0]        iss_rd;
  logic [4:0]        iss_rs1;
  logic [4:0]        iss_rs2;
  logic [XLEN-1:0]   iss_imm;
  logic [XLEN-1:0]   iss_pc;
  logic              iss_is_vec;
  logic              iss_is_imm;
  logic              iss_is_pc;

  modport master (
    output rdy, flush, enq_valid, enq_inst, enq_pc, op1_rdy, op2_rdy, dst_ready,
    input  full, count, ovf_err, pre_rs1, pre_rs2, issue_valid, iss_type,
           iss_name, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_pc, iss_is_vec,
           iss_is_imm, iss_is_pc
  );

  modport slave (
    input  rdy, flush, enq_valid, enq_inst, enq_pc, op1_rdy, op2_rdy, dst_ready,
    output full, count, ovf_err, pre_rs1, pre_rs2, issue_valid, iss_type,
           iss_name, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_pc, iss_is_vec,
           iss_is_imm, iss_is_pc
  );

endinterface

// File: rtl/inst_issue_queue_decode.sv
// Combinational decoder for the queue head: instruction word -> type, op id,
// register indices, sign-extended immediate and operand-select flags.
module inst_decode
  import inst_issue_queue_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        alt;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opc = inst[OPC_LSB +: 7];
  assign f3  = inst[F3_LSB  +: 3];
  assign rd  = inst[RD_LSB  +: 5];
  assign rs1 = inst[RS1_LSB +: 5];
  assign rs2 = inst[RS2_LSB +: 5];
  // funct7 bit 5 selects SUB/SRA variants
  assign alt = inst[30];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    dec      = '0;
    dec.typ  = QUE_NONE;
    dec.name = OP_NOP;
    case (opc)
      OPC_OP: begin
        dec.typ = QUE_REG;
        dec.rd  = rd;
        dec.rs1 = rs1;
        dec.rs2 = rs2;
        case (f3)
          3'b000:  dec.name = alt ? OP_SUB : OP_ADD;
          3'b001:  dec.name = OP_SLL;
          3'b010:  dec.name = OP_SLT;
          3'b011:  dec.name = OP_SLTU;
          3'b100:  dec.name = OP_XOR;
          3'b101:  dec.name = alt ? OP_SRA : OP_SRL;
          3'b110:  dec.name = OP_OR;
          default: dec.name = OP_AND;
        endcase
      end
      OPC_OP_IMM: begin
        dec.typ    = QUE_REG;
        dec.rd     = rd;
        dec.rs1    = rs1;
        dec.imm    = imm_i;
        dec.is_imm = 1'b1;
        case (f3)
          3'b000:  dec.name = OP_ADDI;
          3'b001:  dec.name = OP_SLLI;
          3'b010:  dec.name = OP_SLTI;
          3'b011:  dec.name = OP_SLTIU;
          3'b100:  dec.name = OP_XORI;
          3'b101:  dec.name = alt ? OP_SRAI : OP_SRLI;
          3'b110:  dec.name = OP_ORI;
          default: dec.name = OP_ANDI;
        endcase
      end
      OPC_LOAD: begin
        dec.typ    = QUE_REG;
        dec.rd     = rd;
        dec.rs1    = rs1;
        dec.imm    = imm_i;
        dec.is_imm = 1'b1;
        case (f3)
          3'b000:  dec.name = OP_LB;
          3'b001:  dec.name = OP_LH;
          3'b100:  dec.name = OP_LBU;
          3'b101:  dec.name = OP_LHU;
          default: dec.name = OP_LW;
        endcase
      end
      OPC_STORE: begin
        dec.typ    = QUE_STORE;
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.imm    = imm_s;
        dec.is_imm = 1'b1;
        case (f3)
          3'b000:  dec.name = OP_SB;
          3'b001:  dec.name = OP_SH;
          default: dec.name = OP_SW;
        endcase
      end
      OPC_BRANCH: begin
        dec.typ = QUE_BRANCH;
        dec.rs1 = rs1;
        dec.rs2 = rs2;
        dec.imm = imm_b;
        case (f3)
          3'b000:  dec.name = OP_BEQ;
          3'b001:  dec.name = OP_BNE;
          3'b100:  dec.name = OP_BLT;
          3'b101:  dec.name = OP_BGE;
          3'b110:  dec.name = OP_BLTU;
          default: dec.name = OP_BGEU;
        endcase
      end
      OPC_LUI: begin
        dec.typ    = QUE_REG;
        dec.name   = OP_LUI;
        dec.rd     = rd;
        dec.imm    = imm_u;
        dec.is_imm = 1'b1;
      end
      OPC_AUIPC: begin
        dec.typ    = QUE_REG;
        dec.name   = OP_AUIPC;
        dec.rd     = rd;
        dec.imm    = imm_u;
        dec.is_imm = 1'b1;
        dec.is_pc  = 1'b1;
      end
      OPC_JAL: begin
        dec.typ   = QUE_REG;
        dec.name  = OP_JAL;
        dec.rd    = rd;
        dec.imm   = imm_j;
        dec.is_pc = 1'b1;
      end
      OPC_JALR: begin
        dec.typ    = QUE_REG;
        dec.name   = OP_JALR;
        dec.rd     = rd;
        dec.rs1    = rs1;
        dec.imm    = imm_i;
        dec.is_imm = 1'b1;
      end
      OPC_VEC: begin
        dec.typ    = QUE_REG;
        dec.name   = OP_VADD;
        dec.rd     = rd;
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.is_vec = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_issue_queue.sv
// In-order {pc, inst} queue between fetch and issue; decodes the head entry
// and issues one instruction per cycle when downstream and both operands are ready.
module inst_issue_queue
  import inst_issue_queue_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int XLEN        = XLEN_DEF,
  parameter int AFULL_SLACK = 2
)
(
  input  logic             clk,
  input  logic             rst,
  inst_issue_queue_if.slave q
);

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];

  logic [ADDR_W:0]   head;
  logic [ADDR_W:0]   tail;
  logic [ADDR_W-1:0] head_idx;
  logic [ADDR_W-1:0] tail_idx;
  logic [ADDR_W:0]   occ;
  logic              empty;
  logic              at_cap;
  logic              enq_ok;
  logic              go;
  dec_t              hd;

  logic              ovf_q;
  logic              iss_vld_q;
  dec_t              iss_dec_q;
  logic [XLEN-1:0]   iss_pc_q;

  assign head_idx = head[ADDR_W-1:0];
  assign tail_idx = tail[ADDR_W-1:0];
  assign occ      = tail - head;
  assign empty    = (head == tail);
  assign at_cap   = (head[ADDR_W] != tail[ADDR_W]) && (head_idx == tail_idx);
  assign enq_ok   = q.enq_valid && !at_cap;
  assign go       = q.dst_ready && !empty && q.op1_rdy && q.op2_rdy;

  inst_decode u_dec (
    .inst (inst_mem[head_idx][31:0]),
    .dec  (hd)
  );

  // Data arrays carry no reset; only pointers qualify their contents.
  always_ff @(posedge clk) begin
    if (!rst && q.rdy && !q.flush && enq_ok) begin
      pc_mem[tail_idx]   <= q.enq_pc;
      inst_mem[tail_idx] <= q.enq_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      ovf_q     <= 1'b0;
      iss_vld_q <= 1'b0;
      iss_dec_q <= '0;
      iss_pc_q  <= '0;
    end else if (q.rdy) begin
      if (q.flush) begin
        head      <= '0;
        tail      <= '0;
        iss_vld_q <= 1'b0;
      end else begin
        // A slot freed by this cycle's issue is not reusable until next cycle.
        if (q.enq_valid && at_cap)
          ovf_q <= 1'b1;
        if (enq_ok)
          tail <= tail + 1'b1;
        iss_vld_q <= go;
        if (go) begin
          head      <= head + 1'b1;
          iss_dec_q <= hd;
          iss_pc_q  <= pc_mem[head_idx];
        end
      end
    end
  end

  assign q.count       = occ;
  assign q.full        = (DEPTH - int'(occ)) <= AFULL_SLACK;
  assign q.ovf_err     = ovf_q;
  assign q.pre_rs1     = hd.rs1;
  assign q.pre_rs2     = hd.rs2;
  assign q.issue_valid = iss_vld_q;
  assign q.iss_type    = iss_dec_q.typ;
  assign q.iss_name    = iss_dec_q.name;
  assign q.iss_rd      = iss_dec_q.rd;
  assign q.iss_rs1     = iss_dec_q.rs1;
  assign q.iss_rs2     = iss_dec_q.rs2;
  assign q.iss_imm     = XLEN'($signed(iss_dec_q.imm));
  assign q.iss_pc      = iss_pc_q;
  assign q.iss_is_vec  = iss_dec_q.is_vec;
  assign q.iss_is_imm  = iss_dec_q.is_imm;
  assign q.iss_is_pc   = iss_dec_q.is_pc;

endmodule

// File: tb/tb_inst_issue_queue.sv
// Bench for inst_issue_queue: directed scenarios plus random traffic against
// a queue-level reference model, with a scoreboard monitor on the issue port.
module tb_inst_issue_queue;
  import inst_issue_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int XLEN  = 32;
  localparam int SLACK = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    dec_t        d;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_issue_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) qi ();

  inst_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AFULL_SLACK(SLACK)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qi)
  );

  int   checks = 0;
  int   errors = 0;
  rec_t cur;
  rec_t mq[$];
  rec_t exp_q[$];
  bit   m_ovf;
  bit   edge_active;
  bit   m_go;
  bit   m_cap;
  logic [31:0] next_pc = 32'h1000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Builds an instruction from its fields, together with what it should decode to.
  function automatic rec_t mk_rec(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] pc);
    rec_t r;
    r       = '0;
    r.pc    = pc;
    r.d.typ = QUE_REG;
    r.d.rd  = rd;
    r.d.rs1 = rs1;
    r.d.rs2 = rs2;
    case (kind)
      0: begin r.d.name = OP_ADD; r.inst = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011}; end
      1: begin r.d.name = OP_SUB; r.inst = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011}; end
      2: begin
        r.d.name = OP_ADDI; r.d.rs2 = 5'd0; r.d.is_imm = 1'b1;
        r.d.imm  = {{20{imm[11]}}, imm[11:0]};
        r.inst   = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      end
      3: begin
        r.d.name = OP_SW; r.d.typ = QUE_STORE; r.d.rd = 5'd0; r.d.is_imm = 1'b1;
        r.d.imm  = {{20{imm[11]}}, imm[11:0]};
        r.inst   = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      end
      4: begin
        r.d.name = OP_BEQ; r.d.typ = QUE_BRANCH; r.d.rd = 5'd0;
        r.d.imm  = {{19{imm[12]}}, imm[12:1], 1'b0};
        r.inst   = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      end
      5: begin
        r.d.name = OP_LUI; r.d.rs1 = 5'd0; r.d.rs2 = 5'd0; r.d.is_imm = 1'b1;
        r.d.imm  = {imm[31:12], 12'b0};
        r.inst   = {imm[31:12], rd, 7'b0110111};
      end
      default: begin
        r.d.name = OP_VADD; r.d.is_vec = 1'b1;
        r.inst   = {7'b0, rs2, rs1, 3'b000, rd, 7'b1010111};
      end
    endcase
    return r;
  endfunction

  task automatic present(input rec_t r);
    cur          = r;
    qi.enq_inst  = r.inst;
    qi.enq_pc    = r.pc;
    qi.enq_valid = 1'b1;
    next_pc      = next_pc + 32'd4;
  endtask

  task automatic set_enq(input bit v);
    if (v)
      present(mk_rec(int'($urandom_range(0, 6)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), $urandom, next_pc));
    else
      qi.enq_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input bit dr, input bit o1, input bit o2);
    qi.dst_ready = dr;
    qi.op1_rdy   = o1;
    qi.op2_rdy   = o2;
  endtask

  task automatic drain(input string name);
    set_enq(1'b0);
    set_ctl(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 64 && qi.count != 0; i++) tick();
    check(name, qi.count, 0);
    tick();
  endtask

  // Reference model: a plain FIFO of records updated at each active edge.
  always @(posedge clk) begin
    edge_active = 1'b0;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_ovf = 1'b0;
    end else if (qi.rdy) begin
      edge_active = 1'b1;
      if (qi.flush) begin
        mq.delete();
      end else begin
        m_cap = (mq.size() == DEPTH);
        m_go  = qi.dst_ready && qi.op1_rdy && qi.op2_rdy && (mq.size() > 0);
        if (qi.enq_valid && m_cap) m_ovf = 1'b1;
        if (m_go) exp_q.push_back(mq.pop_front());
        if (qi.enq_valid && !m_cap) mq.push_back(cur);
      end
    end
  end

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    rec_t e;
    if (!rst) begin
      if (edge_active && qi.issue_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", qi.iss_pc, 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("iss_pc", qi.iss_pc, e.pc);
          check("iss_name", qi.iss_name, e.d.name);
          check("iss_rd", qi.iss_rd, e.d.rd);
          check("iss_imm", qi.iss_imm, e.d.imm);
          check("iss_fields", {qi.iss_type, qi.iss_rs1, qi.iss_rs2, qi.iss_is_vec, qi.iss_is_imm, qi.iss_is_pc},
                {e.d.typ, e.d.rs1, e.d.rs2, e.d.is_vec, e.d.is_imm, e.d.is_pc});
        end
      end
      if (edge_active) check("missed_issue", exp_q.size(), 0);
      check("count", qi.count, mq.size());
      check("full", qi.full, (DEPTH - mq.size()) <= SLACK);
      check("ovf_err", qi.ovf_err, m_ovf);
      if (mq.size() > 0) begin
        check("pre_rs1", qi.pre_rs1, mq[0].d.rs1);
        check("pre_rs2", qi.pre_rs2, mq[0].d.rs2);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout reached at t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] first_pc;
    logic [95:0] snap;
    int          n_enq;

    rst          = 1'b1;
    qi.rdy       = 1'b1;
    qi.flush     = 1'b0;
    qi.enq_valid = 1'b0;
    qi.enq_inst  = '0;
    qi.enq_pc    = '0;
    set_ctl(1'b0, 1'b1, 1'b1);
    cur          = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_count", qi.count, 0);
    check("rst_issue_valid", qi.issue_valid, 0);
    check("rst_ovf", qi.ovf_err, 0);
    check("rst_full", qi.full, 0);
    check("rst_iss", {qi.iss_pc, qi.iss_imm, qi.iss_name, qi.iss_rd, qi.iss_type}, 0);

    // Fill: 14 entries with downstream blocked.
    for (int i = 0; i < 14; i++) begin
      set_enq(1'b1);
      tick();
      if (i == 12) check("fill_full_at13", qi.full, 0);
    end
    set_enq(1'b0);
    check("fill_count", qi.count, 14);
    check("fill_full", qi.full, 1);
    check("fill_no_issue", qi.issue_valid, 0);
    drain("fill_drain");

    // Stream: one enqueue per cycle, everything ready.
    first_pc = next_pc;
    set_enq(1'b1);
    tick();
    check("stream_lat", qi.issue_valid, 0);
    for (int k = 1; k <= 8; k++) begin
      set_enq(1'b1);
      tick();
      check("stream_valid", qi.issue_valid, 1);
      check("stream_count", qi.count, 1);
      check("stream_pc", qi.iss_pc, first_pc + 32'(4 * (k - 1)));
    end
    drain("stream_drain");

    // Operand stall: addi x5, x1, 3 with rs1 not ready.
    set_ctl(1'b1, 1'b0, 1'b1);
    present(mk_rec(2, 5'd5, 5'd1, 5'd0, 32'd3, next_pc));
    tick();
    set_enq(1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_no_issue", qi.issue_valid, 0);
      check("stall_pre_rs1", qi.pre_rs1, 1);
    end
    qi.op1_rdy = 1'b1;
    tick();
    check("stall_release", qi.issue_valid, 1);
    check("stall_imm", qi.iss_imm, 3);
    check("stall_rd", qi.iss_rd, 5);
    drain("stall_drain");

    // Random interleaving across pointer wrap.
    n_enq = 0;
    for (int c = 0; c < 400 && n_enq < 40; c++) begin
      if (!qi.full && $urandom_range(0, 3) != 0) begin
        set_enq(1'b1);
        n_enq++;
      end else begin
        set_enq(1'b0);
      end
      set_ctl(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      tick();
    end
    check("wrap_enq_done", n_enq, 40);
    drain("wrap_drain");

    // Flush with a simultaneous enqueue and issue.
    set_ctl(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      set_enq(1'b1);
      tick();
    end
    check("flush_pre_count", qi.count, 7);
    qi.flush = 1'b1;
    set_enq(1'b1);
    set_ctl(1'b1, 1'b1, 1'b1);
    tick();
    qi.flush = 1'b0;
    set_enq(1'b0);
    set_ctl(1'b0, 1'b1, 1'b1);
    check("flush_count", qi.count, 0);
    check("flush_issue_valid", qi.issue_valid, 0);
    set_enq(1'b1);
    tick();
    set_enq(1'b0);
    check("flush_reuse_count", qi.count, 1);
    drain("flush_drain");

    // Overflow, then freeze with issue_valid high.
    set_ctl(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      set_enq(1'b1);
      tick();
    end
    check("ovf_before", qi.ovf_err, 0);
    set_enq(1'b1);
    tick();
    check("ovf_set", qi.ovf_err, 1);
    check("ovf_count", qi.count, 16);
    set_enq(1'b1);
    set_ctl(1'b1, 1'b1, 1'b1);
    tick();
    check("ovf_simul_count", qi.count, 15);
    check("ovf_simul_issue", qi.issue_valid, 1);
    snap = {qi.iss_pc, qi.iss_imm, 16'(qi.count), qi.issue_valid, qi.ovf_err, qi.full,
            qi.pre_rs1, qi.iss_name, 3'b0};
    qi.rdy   = 1'b0;
    qi.flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_hold", {qi.iss_pc, qi.iss_imm, 16'(qi.count), qi.issue_valid, qi.ovf_err, qi.full,
                            qi.pre_rs1, qi.iss_name, 3'b0} ^ snap, 0);
    end
    qi.rdy   = 1'b1;
    qi.flush = 1'b0;
    drain("ovf_drain");
    check("ovf_sticky", qi.ovf_err, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
